pattern_stream_driver: RTL
==========================

Name: pattern_stream_driver

Overview:
- Character-stream source and acknowledge responder that sits opposite the pattern detector.
- Software loads a byte sequence into an internal buffer, then the block plays it out one byte per clock on `data`.
- It watches the detector's `found_pattern` flag, answers each match with a one-cycle `ack` pulse after a programmable delay, and counts the acknowledged matches.

Parameters:
- DEPTH, 32, buffer capacity in bytes (power of two, at least 2).
- ACK_DELAY, 2, extra cycles between seeing `found_pattern` and issuing `ack` (0 or more).
- CNT_W, 16, width of the saturating match counter.

Ports:
- clk  in  1  single clock; all logic rises on posedge
- reset_sync  in  1  synchronous, active-high reset
- load_valid  in  1  byte offered on load_data
- load_data  in  8  byte to append to the buffer
- load_ready  out  1  buffer accepts a byte this cycle
- start  in  1  begin playback (level sampled in IDLE)
- loop_en  in  1  replay the buffer continuously while high
- data  out  8  stream byte to the detector (registered)
- data_valid  out  1  `data` holds a buffered byte
- found_pattern  in  1  match flag from the detector, held until ack
- ack  out  1  one-cycle acknowledge to the detector
- match_count  out  CNT_W  acknowledged matches, saturating
- busy  out  1  state is PLAY
- done  out  1  one-cycle pulse when playback ends

Behaviour:
- Reset values, on any clk edge with reset_sync=1: data=8'h00, data_valid=0, load_ready=0, ack=0, match_count=0, busy=0, done=0, state=IDLE, length=0, pointers=0. Buffer contents need not be cleared.
- Reset mid-operation aborts playback and any pending ack. The first post-reset cycle shows load_ready=1.
- States: IDLE, PLAY, DONE.
- IDLE:
  - load_ready = (length < DEPTH).
  - When load_valid && load_ready, store at buf[length] and increment length.
  - When start=1 and length>0, go to PLAY with rd_ptr=0. start with length=0 is ignored.
  - Load and start in the same cycle: the load is accepted, and start uses the old length.
- PLAY:
  - load_ready=0. Writes are dropped and not buffered.
  - Each cycle registers data<=buf[rd_ptr], data_valid<=1.
  - First byte appears the cycle after start was sampled.
  - When rd_ptr==length-1 and loop_en=1: rd_ptr<=0, no bubble.
  - When rd_ptr==length-1 and loop_en=0: go to DONE.
  - loop_en is sampled only at the wrap point.
- DONE:
  - data<=8'h00, data_valid<=0, done=1 for exactly one cycle, then IDLE.
  - length is retained, so start replays without reloading.
- Outside PLAY: data=8'h00 and data_valid=0.
- busy=1 exactly while in PLAY.
- Ack responder runs independently of playback state:
  - WAIT: found_pattern sampled 1 → if ACK_DELAY=0 go to PULSE, else go to DELAY with cnt=ACK_DELAY.
  - DELAY: decrement cnt; at cnt==1 go to PULSE.
  - PULSE: ack=1 for one cycle, match_count increments (holds at all-ones), then go to BLANK.
  - BLANK: one cycle with found_pattern ignored while the detector clears, then WAIT.
- Ack timing: found_pattern sampled high at edge t gives ack high during cycle t+1+ACK_DELAY.
- found_pattern falling during DELAY does not cancel the pending ack.
- No combinational paths: every output is registered.

Decomposition:
- Package `pattern_pkg`:
  - `play_state_t` enum (IDLE, PLAY, DONE).
  - `ack_state_t` enum (WAIT, DELAY, PULSE, BLANK).
  - `IDLE_BYTE` = 8'h00.
  - `byte_t` typedef (logic [7:0]).
- One sub-module, `pattern_ack_responder`: ack FSM, delay counter, saturating match counter. Parameters ACK_DELAY and CNT_W.
- The top level holds the buffer, load logic and playback FSM.

Test Plan:
- Load "boabz", loop_en=0, pulse start → data = b,o,a,b,z on 5 consecutive cycles starting the cycle after start. Then done=1 for one cycle, data=8'h00, data_valid=0, busy low after 5 cycles.
- ACK_DELAY=2, found_pattern raised at edge 10 and held → ack=1 only in cycle 13, match_count=1. found_pattern still high in cycle 14 is ignored (BLANK). With found_pattern still held, the next ack comes in cycle 18.
- DEPTH=32, offer 33 bytes with load_valid held → load_ready drops after the 32nd accept, length=32, 33rd byte not stored. A start during load accepts the concurrent byte first.
- Load "ab", loop_en=1, start → a,b,a,b,… with no gaps. Drop loop_en during an 'a' cycle → stream ends after the following 'b', then done pulse.
- Assert reset_sync during PLAY with ack pending → next cycle data=00, data_valid=0, busy=0, ack=0, match_count=0, length=0. start then ignored until a new load.
- CNT_W=2, five acknowledged matches → match_count sequence 1,2,3,3,3. ack still pulses for every match.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern stream driver and its ack responder.
package pattern_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDone
  } play_state_t;

  typedef enum logic [1:0] {
    AckWait,
    AckDelay,
    AckPulse,
    AckBlank
  } ack_state_t;

  localparam byte_t IDLE_BYTE = 8'h00;

endpackage

// File: rtl/pattern_ack_responder.sv
// Answers each detector match with a delayed one-cycle ack and counts matches (saturating).
module pattern_ack_responder
  import pattern_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_sync_i,
  input  logic             found_pattern_i,
  output logic             ack_o,
  output logic [CNT_W-1:0] match_count_o
);

  localparam int unsigned DlyW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY + 1) : 1;
  localparam logic [DlyW-1:0] DlyInit = DlyW'(ACK_DELAY);
  localparam logic [CNT_W-1:0] CntMax = '1;

  ack_state_t       state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ack_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      AckWait: begin
        if (found_pattern_i) begin
          if (ACK_DELAY == 0) begin
            state_d = AckPulse;
          end else begin
            state_d = AckDelay;
            dly_d   = DlyInit;
          end
        end
      end
      AckDelay: begin
        dly_d = dly_q - DlyW'(1);
        if (dly_q == DlyW'(1)) state_d = AckPulse;
      end
      AckPulse: state_d = AckBlank;
      // Detector is still clearing its flag; ignore it for this cycle.
      AckBlank: state_d = AckWait;
      default:  state_d = AckWait;
    endcase
    if (state_d == AckPulse) begin
      ack_d = 1'b1;
      if (count_q != CntMax) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_sync_i) begin
      state_q <= AckWait;
      dly_q   <= '0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign ack_o         = ack_q;
  assign match_count_o = count_q;

endmodule

// File: rtl/pattern_stream_driver.sv
// Byte buffer loaded by software and replayed one byte per clock, plus the ack responder.
module pattern_stream_driver
  import pattern_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic             loop_en,
  output logic [7:0]       data,
  output logic             data_valid,
  input  logic             found_pattern,
  output logic             ack,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;

  byte_t            mem_q [DEPTH];
  play_state_t      state_q, state_d;
  logic [LenW-1:0]  length_q, length_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  byte_t            data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             wr_en;
  logic             last;

  assign last = (LenW'(rd_ptr_q) == (length_q - LenW'(1)));

  // The byte for the next cycle is fetched here so the stream is registered with no bubble.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = IDLE_BYTE;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_en = load_valid && ready_q;
        if (wr_en) length_d = length_q + LenW'(1);
        if (start && (length_q != '0)) begin
          state_d  = StPlay;
          rd_ptr_d = '0;
          data_d   = mem_q[0];
          valid_d  = 1'b1;
        end
      end
      StPlay: begin
        valid_d = 1'b1;
        if (last) begin
          if (loop_en) begin
            rd_ptr_d = '0;
            data_d   = mem_q[0];
          end else begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + AddrW'(1);
          data_d   = mem_q[rd_ptr_d];
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d  = (state_d == StPlay);
    ready_d = (state_d == StIdle) && (length_d < LenW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q  <= StIdle;
      length_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= IDLE_BYTE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_sync && wr_en) mem_q[length_q[AddrW-1:0]] <= load_data;
  end

  pattern_ack_responder #(
    .ACK_DELAY (ACK_DELAY),
    .CNT_W     (CNT_W)
  ) u_ack (
    .clk_i           (clk),
    .reset_sync_i    (reset_sync),
    .found_pattern_i (found_pattern),
    .ack_o           (ack),
    .match_count_o   (match_count)
  );

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule
